// File: rtl/video_input_arbiter.sv
// Buffers NUM_CH pixel-word write streams in per-channel FIFOs and round-robin
// arbitrates them onto one Avalon-MM write master into per-channel frame buffers.
module video_input_arbiter #(
   parameter int                NUM_CH      = 10,
   parameter int                DATA_W      = 32,
   parameter int                FIFO_DEPTH  = 16,
   parameter int                ADDR_W      = 32,
   parameter int                FRAME_WORDS = 76800,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000,
   parameter logic [ADDR_W-1:0] CH_STRIDE   = 32'h0010_0000
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       enable,
   input  logic [NUM_CH-1:0]          sync_frame,
   input  logic [NUM_CH*DATA_W-1:0]   in_writedata,
   input  logic [NUM_CH-1:0]          in_write,
   output logic [NUM_CH-1:0]          in_waitrequest,
   output logic [ADDR_W-1:0]          avm_address,
   output logic [DATA_W-1:0]          avm_writedata,
   output logic                       avm_write,
   input  logic                       avm_waitrequest,
   output logic [NUM_CH-1:0]          frame_done,
   output logic [NUM_CH*5-1:0]        fifo_level
);

   localparam int                PW         = $clog2(FIFO_DEPTH);
   localparam int                CW         = PW + 1;
   localparam int                GW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int                IW         = $clog2(FRAME_WORDS);
   localparam logic [IW-1:0]     LAST_IDX   = IW'(FRAME_WORDS - 1);
   localparam logic [CW-1:0]     FULL_CNT   = CW'(FIFO_DEPTH);
   localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(DATA_W / 8);

   typedef enum logic [0:0] {IDLE = 1'b0, ISSUE = 1'b1} state_t;

   logic [DATA_W-1:0] mem       [NUM_CH][FIFO_DEPTH];
   logic [PW-1:0]     wr_ptr    [NUM_CH];
   logic [PW-1:0]     rd_ptr    [NUM_CH];
   logic [PW-1:0]     rd_nxt    [NUM_CH];
   logic [CW-1:0]     count     [NUM_CH];
   logic [CW-1:0]     count_nxt [NUM_CH];
   logic [IW-1:0]     idx       [NUM_CH];
   logic [IW-1:0]     idx_nxt   [NUM_CH];

   logic [NUM_CH-1:0] full, push, pop, not_empty, avail, done_nxt, frame_done_r;
   logic [NUM_CH*5-1:0] level_r;

   state_t            state, state_nxt;
   logic [GW-1:0]     grant, grant_nxt, rr_ptr, rr_nxt, sel;
   logic [GW:0]       pick_res;
   logic              accept, load, drop;
   logic              write_r;
   logic [ADDR_W-1:0] addr_r, addr_nxt;
   logic [DATA_W-1:0] data_r, data_nxt;

   // First requesting channel at or after start, cyclically; MSB flags a hit.
   function automatic logic [GW:0] pick(input logic [NUM_CH-1:0] req, input logic [GW-1:0] start);
      logic [GW:0] res;
      int          best;
      int          off;
      res  = {(GW+1){1'b0}};
      best = NUM_CH;
      for (int j = 0; j < NUM_CH; j++) begin
         off = (j >= int'(start)) ? (j - int'(start)) : (j + NUM_CH - int'(start));
         if (req[j] && (off < best)) begin
            best = off;
            res  = {1'b1, GW'(j)};
         end
      end
      return res;
   endfunction

   function automatic logic [4:0] sat5(input logic [CW-1:0] c);
      logic [31:0] w;
      w = 32'(c);
      return (w > 32'd31) ? 5'd31 : w[4:0];
   endfunction

   assign accept = write_r & ~avm_waitrequest;

   // Per-channel FIFO bookkeeping and word index update.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         push[i]      = in_write[i] & ~in_waitrequest[i];
         pop[i]       = accept & (grant == GW'(i));
         count_nxt[i] = count[i] + CW'(push[i]) - CW'(pop[i]);
         rd_nxt[i]    = rd_ptr[i] + PW'(pop[i]);
         not_empty[i] = (count[i] != {CW{1'b0}});
         // Words pushed this cycle are deliberately not visible to the next grant.
         avail[i]     = ((count[i] - CW'(pop[i])) != {CW{1'b0}});
         done_nxt[i]  = pop[i] & (idx[i] == LAST_IDX);
         if (sync_frame[i]) begin
            idx_nxt[i] = {IW{1'b0}};
         end else if (pop[i]) begin
            idx_nxt[i] = (idx[i] == LAST_IDX) ? {IW{1'b0}} : idx[i] + IW'(1'b1);
         end else begin
            idx_nxt[i] = idx[i];
         end
      end
   end

   // Arbiter next-state, grant selection and master output load control.
   always_comb begin
      state_nxt = state;
      grant_nxt = grant;
      rr_nxt    = rr_ptr;
      sel       = grant;
      load      = 1'b0;
      drop      = 1'b0;
      pick_res  = pick(not_empty, rr_ptr);
      case (state)
         IDLE: begin
            if (enable && pick_res[GW]) begin
               grant_nxt = pick_res[GW-1:0];
               state_nxt = ISSUE;
            end else begin
               state_nxt = IDLE;
            end
         end
         ISSUE: begin
            if (!write_r) begin
               load = 1'b1;
            end else if (accept) begin
               rr_nxt   = (grant == GW'(NUM_CH - 1)) ? {GW{1'b0}} : grant + GW'(1'b1);
               pick_res = pick(avail, rr_nxt);
               if (enable && pick_res[GW]) begin
                  grant_nxt = pick_res[GW-1:0];
                  sel       = pick_res[GW-1:0];
                  load      = 1'b1;
               end else begin
                  state_nxt = IDLE;
                  drop      = 1'b1;
               end
            end else begin
               state_nxt = ISSUE;
            end
         end
         default: begin
            state_nxt = IDLE;
            drop      = 1'b1;
         end
      endcase
   end

   // Address and head word of the channel about to be presented.
   always_comb begin
      addr_nxt = BASE_ADDR + ADDR_W'(sel) * CH_STRIDE + ADDR_W'(idx_nxt[sel]) * WORD_BYTES;
      data_nxt = mem[sel][rd_nxt[sel]];
   end

   // FIFO storage; contents need no reset because occupancy gates every read.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (push[i]) begin
            mem[i][wr_ptr[i]] <= in_writedata[i*DATA_W +: DATA_W];
         end
      end
   end

   // FIFO pointers, occupancy, word indices and status registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            wr_ptr[i] <= {PW{1'b0}};
            rd_ptr[i] <= {PW{1'b0}};
            count[i]  <= {CW{1'b0}};
            idx[i]    <= {IW{1'b0}};
         end
         full         <= {NUM_CH{1'b0}};
         level_r      <= {(NUM_CH*5){1'b0}};
         frame_done_r <= {NUM_CH{1'b0}};
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            wr_ptr[i]        <= wr_ptr[i] + PW'(push[i]);
            rd_ptr[i]        <= rd_nxt[i];
            count[i]         <= count_nxt[i];
            idx[i]           <= idx_nxt[i];
            full[i]          <= (count_nxt[i] == FULL_CNT);
            level_r[i*5 +: 5] <= sat5(count_nxt[i]);
         end
         frame_done_r <= done_nxt;
      end
   end

   // Arbiter state and registered master outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         grant   <= {GW{1'b0}};
         rr_ptr  <= {GW{1'b0}};
         write_r <= 1'b0;
         addr_r  <= {ADDR_W{1'b0}};
         data_r  <= {DATA_W{1'b0}};
      end else begin
         state  <= state_nxt;
         grant  <= grant_nxt;
         rr_ptr <= rr_nxt;
         if (load) begin
            write_r <= 1'b1;
            addr_r  <= addr_nxt;
            data_r  <= data_nxt;
         end else if (drop) begin
            write_r <= 1'b0;
         end
      end
   end

   assign in_waitrequest = {NUM_CH{reset}} | full;
   assign avm_address    = addr_r;
   assign avm_writedata  = data_r;
   assign avm_write      = write_r;
   assign frame_done     = frame_done_r;
   assign fifo_level     = level_r;

endmodule

// File: tb/tb_video_input_arbiter.sv
// Directed, table-driven bench for video_input_arbiter; a second instance
// with FRAME_WORDS=4 covers frame wrap and frame_done.
module tb_video_input_arbiter;

   logic          clk;
   logic          reset;
   logic          enable;
   logic [9:0]    sync_frame;
   logic [319:0]  in_writedata;
   logic [9:0]    in_write;
   logic          avm_waitrequest;

   logic [9:0]    in_waitrequest, in_waitrequest4;
   logic [31:0]   avm_address, avm_address4;
   logic [31:0]   avm_writedata, avm_writedata4;
   logic          avm_write, avm_write4;
   logic [9:0]    frame_done, frame_done4;
   logic [49:0]   fifo_level, fifo_level4;

   int errors = 0;
   int checks = 0;

   logic [31:0] exp_a[$];
   logic [31:0] exp_d[$];

   typedef struct {
      int          ch;
      logic [31:0] data;
      logic [31:0] addr;
   } vec_t;
   vec_t tbl [6];

   video_input_arbiter dut (
      .clk(clk), .reset(reset), .enable(enable), .sync_frame(sync_frame),
      .in_writedata(in_writedata), .in_write(in_write), .in_waitrequest(in_waitrequest),
      .avm_address(avm_address), .avm_writedata(avm_writedata), .avm_write(avm_write),
      .avm_waitrequest(avm_waitrequest), .frame_done(frame_done), .fifo_level(fifo_level)
   );

   video_input_arbiter #(.FRAME_WORDS(4)) dut4 (
      .clk(clk), .reset(reset), .enable(enable), .sync_frame(sync_frame),
      .in_writedata(in_writedata), .in_write(in_write), .in_waitrequest(in_waitrequest4),
      .avm_address(avm_address4), .avm_writedata(avm_writedata4), .avm_write(avm_write4),
      .avm_waitrequest(avm_waitrequest), .frame_done(frame_done4), .fifo_level(fifo_level4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      reset           = 1'b1;
      in_write        = 10'h000;
      sync_frame      = 10'h000;
      avm_waitrequest = 1'b0;
      enable          = 1'b1;
      tick;
      tick;
      reset = 1'b0;
   endtask

   task automatic push1(input int ch, input logic [31:0] d);
      in_writedata[ch*32 +: 32] = d;
      in_write[ch]              = 1'b1;
      tick;
      in_write[ch] = 1'b0;
   endtask

   // One word into an idle arbiter with no slave stall: exact latency and address.
   task automatic single(input int ch, input logic [31:0] d, input logic [31:0] a);
      push1(ch, d);
      chk($sformatf("single%0d_lat0", ch), avm_write, 1'b0);
      tick;
      chk($sformatf("single%0d_lat1", ch), avm_write, 1'b0);
      tick;
      chk($sformatf("single%0d_write", ch), avm_write, 1'b1);
      chk($sformatf("single%0d_addr", ch), avm_address, a);
      chk($sformatf("single%0d_data", ch), avm_writedata, d);
      tick;
      chk($sformatf("single%0d_done", ch), avm_write, 1'b0);
   endtask

   // Every sampled write (slave never stalls here) is popped against the queues.
   task automatic collect(input int budget, input bit contig, input string nm);
      int seen  = 0;
      int first = -1;
      int last  = -1;
      for (int c = 0; c < budget; c++) begin
         if (exp_a.size() == 0) break;
         if (avm_write) begin
            chk($sformatf("%s_addr%0d", nm, seen), avm_address, exp_a.pop_front());
            chk($sformatf("%s_data%0d", nm, seen), avm_writedata, exp_d.pop_front());
            if (first < 0) first = c;
            last = c;
            seen++;
         end
         tick;
      end
      chk($sformatf("%s_missing", nm), exp_a.size(), 0);
      if (contig) chk($sformatf("%s_gaps", nm), last - first, seen - 1);
      exp_a.delete();
      exp_d.delete();
   endtask

   initial begin
      int          accepted;
      int          changes;
      bit          have;
      logic [31:0] a0, d0;
      int          n4;
      int          pulses;
      logic [31:0] fa [5];

      tbl[0] = '{2, 32'hA5A5_0001, 32'h0020_0000};
      tbl[1] = '{0, 32'h0000_1000, 32'h0000_0000};
      tbl[2] = '{9, 32'h0000_9000, 32'h0090_0000};
      tbl[3] = '{2, 32'h0000_2002, 32'h0020_0004};
      tbl[4] = '{5, 32'h0000_5000, 32'h0050_0000};
      tbl[5] = '{2, 32'h0000_2003, 32'h0020_0008};
      fa = '{32'h0010_0000, 32'h0010_0004, 32'h0010_0008, 32'h0010_000C, 32'h0010_0000};

      reset = 1'b1; enable = 1'b1; sync_frame = 10'h000; in_write = 10'h000;
      in_writedata = 320'h0; avm_waitrequest = 1'b0;
      #1;
      chk("rst_inwait_early", in_waitrequest, 10'h3FF);
      tick;
      tick;
      chk("rst_write", avm_write, 1'b0);
      chk("rst_addr", avm_address, 32'h0);
      chk("rst_data", avm_writedata, 32'h0);
      chk("rst_frame_done", frame_done, 10'h000);
      chk("rst_level", fifo_level, 50'h0);
      chk("rst_inwait", in_waitrequest, 10'h3FF);
      reset = 1'b0;
      #1;
      chk("post_rst_inwait", in_waitrequest, 10'h000);
      tick;

      for (int v = 0; v < 6; v++) single(tbl[v].ch, tbl[v].data, tbl[v].addr);

      // Reset while a write to channel 4 is stalled.
      avm_waitrequest = 1'b1;
      push1(4, 32'h4400_0001);
      tick;
      tick;
      chk("stall4_write", avm_write, 1'b1);
      chk("stall4_addr", avm_address, 32'h0040_0000);
      reset = 1'b1;
      #1;
      chk("midrst_inwait", in_waitrequest, 10'h3FF);
      tick;
      chk("midrst_write", avm_write, 1'b0);
      chk("midrst_level", fifo_level, 50'h0);
      tick;
      reset = 1'b0;
      avm_waitrequest = 1'b0;
      #1;
      chk("midrst_inwait_rel", in_waitrequest, 10'h000);
      tick;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("no_replay%0d", k), avm_write, 1'b0);
         tick;
      end
      single(3, 32'h3300_0001, 32'h0030_0000);
      single(2, 32'h2200_0009, 32'h0020_0000);

      // Channel 0 fills its FIFO against a stalled slave.
      avm_waitrequest = 1'b1;
      accepted = 0; changes = 0; have = 1'b0; a0 = 32'h0; d0 = 32'h0;
      for (int k = 0; k < 20; k++) begin
         in_writedata[31:0] = 32'hB000_0000 + 32'(k);
         in_write[0]        = 1'b1;
         if (!in_waitrequest[0]) accepted++;
         tick;
         if (avm_write) begin
            if (!have) begin
               a0 = avm_address; d0 = avm_writedata; have = 1'b1;
            end else if (avm_address !== a0 || avm_writedata !== d0) begin
               changes++;
            end
         end
      end
      in_write[0] = 1'b0;
      chk("bp_accepted", accepted, 16);
      chk("bp_inwait0", in_waitrequest[0], 1'b1);
      chk("bp_level0", fifo_level[4:0], 5'd16);
      chk("bp_stable", changes, 0);
      chk("bp_addr", avm_address, 32'h0000_0000);
      chk("bp_data", avm_writedata, 32'hB000_0000);
      avm_waitrequest = 1'b0;
      for (int n = 0; n < 16; n++) begin
         exp_a.push_back(32'(4 * n));
         exp_d.push_back(32'hB000_0000 + 32'(n));
      end
      collect(40, 1'b1, "drain0");
      chk("drain0_idle", avm_write, 1'b0);
      chk("drain0_inwait", in_waitrequest[0], 1'b0);

      // All channels loaded with three words, then released.
      do_reset;
      avm_waitrequest = 1'b1;
      for (int k = 0; k < 3; k++) begin
         for (int c = 0; c < 10; c++) in_writedata[c*32 +: 32] = 32'hC000_0000 | 32'(c << 8) | 32'(k);
         in_write = 10'h3FF;
         tick;
      end
      in_write = 10'h000;
      avm_waitrequest = 1'b0;
      for (int k = 0; k < 3; k++) begin
         for (int c = 0; c < 10; c++) begin
            exp_a.push_back(32'(c) * 32'h0010_0000 + 32'(4 * k));
            exp_d.push_back(32'hC000_0000 | 32'(c << 8) | 32'(k));
         end
      end
      collect(60, 1'b1, "rr");

      // Frame wrap on the FRAME_WORDS=4 instance.
      do_reset;
      n4 = 0; pulses = 0;
      for (int c = 0; c < 20; c++) begin
         if (frame_done4[1]) begin
            pulses++;
            chk("fd_position", n4, 4);
         end
         if (avm_write4) begin
            if (n4 < 5) begin
               chk($sformatf("fw_addr%0d", n4), avm_address4, fa[n4]);
               chk($sformatf("fw_data%0d", n4), avm_writedata4, 32'hF100_0000 + 32'(n4));
            end
            n4++;
         end
         in_writedata[63:32] = 32'hF100_0000 + 32'(c);
         in_write[1]         = (c < 5);
         tick;
      end
      chk("fw_count", n4, 5);
      chk("fd_pulses", pulses, 1);

      // enable=0 with words queued; sync_frame coinciding with acceptance.
      do_reset;
      single(5, 32'h5500_0001, 32'h0050_0000);
      avm_waitrequest = 1'b1;
      push1(5, 32'h5500_0002);
      tick;
      tick;
      chk("en_pend_addr", avm_address, 32'h0050_0004);
      in_writedata[6*32 +: 32] = 32'h6600_0001;
      in_writedata[2*32 +: 32] = 32'h2200_0001;
      in_write[6] = 1'b1; in_write[2] = 1'b1;
      enable = 1'b0;
      tick;
      in_write = 10'h000;
      chk("en_hold_write", avm_write, 1'b1);
      chk("en_hold_addr", avm_address, 32'h0050_0004);
      chk("en_hold_data", avm_writedata, 32'h5500_0002);
      avm_waitrequest = 1'b0;
      sync_frame[5]   = 1'b1;
      tick;
      sync_frame[5] = 1'b0;
      chk("en_block_write", avm_write, 1'b0);
      push1(5, 32'h5500_0003);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("en_block%0d", k), avm_write, 1'b0);
         tick;
      end
      enable = 1'b1;
      exp_a.push_back(32'h0060_0000); exp_d.push_back(32'h6600_0001);
      exp_a.push_back(32'h0020_0000); exp_d.push_back(32'h2200_0001);
      exp_a.push_back(32'h0050_0000); exp_d.push_back(32'h5500_0003);
      collect(20, 1'b1, "resume");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
